// File: rtl/background_tile_spawner.sv
`default_nettype none
// ============================================================================
// background_tile_spawner
//   Issues load pulses with a pseudo-random spawn X to a scrolling background
//   tile, gates its visibility during respawn and ramps the scroll speed.
//   Revision: 1.0
// ============================================================================
module background_tile_spawner #(
    parameter int          X_MIN          = 0,
    parameter int          X_RANGE_LOG2   = 9,
    parameter int          SPAWN_Y        = -64,
    parameter int          BASE_SPEED     = 64,
    parameter int          SPEED_STEP     = 8,
    parameter int          MAX_SPEED      = 512,
    parameter int          SPEEDUP_EVERY  = 4,
    parameter int          RESPAWN_FRAMES = 4,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               enable,
    input  logic               exceed,
    output logic               load,
    output logic signed [10:0] initialX,
    output logic signed [10:0] initialY,
    output logic               visible,
    output logic signed [31:0] speed,
    output logic [15:0]        respawnCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [15:0]        lfsr;
    logic [15:0]        frame_cnt;
    logic [15:0]        ramp_cnt;
    logic               exceed_q;
    logic               lfsr_fb;
    logic               entering_load;
    logic [16:0]        ramp_inc;
    logic               ramp_hit;
    logic signed [31:0] speed_sum;

    assign lfsr_fb       = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign entering_load = (state_next == LOAD);
    assign ramp_inc      = {1'b0, ramp_cnt} + 17'd1;
    assign ramp_hit      = (32'(ramp_inc) == SPEEDUP_EVERY);
    assign speed_sum     = speed + 32'(SPEED_STEP);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (enable) state_next = LOAD;
            LOAD: state_next = HOLD;
            HOLD: begin
                if (RESPAWN_FRAMES == 0)
                    state_next = RUN;
                else if (startOfFrame && (32'(frame_cnt) == RESPAWN_FRAMES - 1))
                    state_next = RUN;
            end
            RUN:  if (exceed_q) state_next = LOAD;
            default: state_next = IDLE;
        endcase
        if (!enable)
            state_next = IDLE;
    end

    // exceed is registered once so a wrap seen at edge n reloads after edge n+1;
    // it is only captured while running so stale wraps never trigger a respawn.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= IDLE;
            lfsr         <= LFSR_SEED;
            frame_cnt    <= 16'd0;
            ramp_cnt     <= 16'd0;
            exceed_q     <= 1'b0;
            load         <= 1'b0;
            visible      <= 1'b0;
            initialX     <= 11'(X_MIN);
            initialY     <= 11'(SPAWN_Y);
            speed        <= 32'(BASE_SPEED);
            respawnCount <= 16'd0;
        end else begin
            lfsr     <= {lfsr[14:0], lfsr_fb};
            state    <= state_next;
            load     <= entering_load;
            visible  <= (state_next == RUN);
            exceed_q <= exceed && (state == RUN);
            if (entering_load) begin
                initialX  <= 11'(X_MIN) + 11'(lfsr[X_RANGE_LOG2-1:0]);
                initialY  <= 11'(SPAWN_Y);
                frame_cnt <= 16'd0;
                if (respawnCount != 16'hFFFF)
                    respawnCount <= respawnCount + 16'd1;
                if (ramp_hit) begin
                    ramp_cnt <= 16'd0;
                    speed    <= (speed_sum > MAX_SPEED) ? 32'(MAX_SPEED) : speed_sum;
                end else begin
                    ramp_cnt <= ramp_inc[15:0];
                end
            end else if (state == HOLD && startOfFrame) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_background_tile_spawner.sv
`default_nettype none
// ============================================================================
// tb_background_tile_spawner
//   Directed self-checking bench: two instances (default and MAX_SPEED=70).
//   Revision: 1.0
// ============================================================================
module tb_background_tile_spawner;

    logic               clk = 1'b0;
    logic               resetN;
    logic               startOfFrame;
    logic               enable;
    logic               exceed;
    logic               load, load2;
    logic signed [10:0] initialX, initialX2;
    logic signed [10:0] initialY, initialY2;
    logic               visible, visible2;
    logic signed [31:0] speed, speed2;
    logic [15:0]        respawnCount, respawnCount2;

    int n_checks = 0;
    int n_fail   = 0;
    int load_count = 0;
    int lc;
    int first_x;
    logic [15:0] m_lfsr, m_prev;

    background_tile_spawner dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .exceed(exceed), .load(load), .initialX(initialX), .initialY(initialY),
        .visible(visible), .speed(speed), .respawnCount(respawnCount)
    );

    background_tile_spawner #(.MAX_SPEED(70)) dut_cap (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .enable(enable),
        .exceed(exceed), .load(load2), .initialX(initialX2), .initialY(initialY2),
        .visible(visible2), .speed(speed2), .respawnCount(respawnCount2)
    );

    always #5 clk = ~clk;

    // Reference Fibonacci LFSR (taps 16,14,13,11); m_prev is the value the DUT
    // held just before the most recent edge.
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        end
    end

    always @(posedge clk) if (load) load_count++;

    task automatic check(input string tag, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        step();
    endtask

    function automatic int exp_x();
        return int'(m_prev[8:0]);
    endfunction

    task automatic respawn_once(input int n);
        exceed = 1'b1;
        step();
        exceed = 1'b0;
        step();
        check("respawn_load", load, 1);
        check("respawn_x", initialX, exp_x());
        check("respawn_count", respawnCount, n);
        step();
        repeat (4) sof();
    endtask

    initial begin
        resetN = 1'b0; enable = 1'b0; startOfFrame = 1'b0; exceed = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (10) step();
        check("rst_load", load, 0);
        check("rst_visible", visible, 0);
        check("rst_speed", speed, 64);
        check("rst_initialX", initialX, 0);
        check("rst_initialY", initialY, -64);
        check("rst_count", respawnCount, 0);

        // first load on enable
        enable = 1'b1;
        step();
        check("first_load", load, 1);
        check("first_x", initialX, exp_x());
        check("first_y", initialY, -64);
        check("first_count", respawnCount, 1);
        first_x = int'(initialX);
        step();
        check("first_load_end", load, 0);
        check("hold_visible", visible, 0);
        repeat (3) sof();
        check("hold_visible_3", visible, 0);
        sof();
        check("run_visible", visible, 1);

        // single-cycle exceed
        exceed = 1'b1;
        step();
        exceed = 1'b0;
        check("exceed_latency", load, 0);
        step();
        check("exceed_load", load, 1);
        check("exceed_visible", visible, 0);
        check("exceed_x", initialX, exp_x());
        step();
        check("exceed_load_end", load, 0);
        repeat (4) sof();

        // exceed held for 5 cycles: a single respawn
        lc = load_count;
        exceed = 1'b1;
        repeat (5) step();
        exceed = 1'b0;
        step();
        check("held_exceed_loads", load_count - lc, 1);
        check("held_count", respawnCount, 3);
        check("speed_before_4th", speed, 64);
        repeat (4) sof();

        // speed ramp, loads 4..8
        for (int i = 4; i <= 8; i++) begin
            respawn_once(i);
            check("speed_ramp", speed, (i == 8) ? 80 : 72);
            check("speed_capped", speed2, 70);
        end

        // enable dropped mid-HOLD
        exceed = 1'b1;
        step();
        exceed = 1'b0;
        step();
        step();
        sof();
        enable = 1'b0;
        step();
        check("idle_visible", visible, 0);
        check("idle_load", load, 0);
        repeat (3) step();
        check("idle_speed_kept", speed, 80);
        check("idle_count_kept", respawnCount, 9);
        enable = 1'b1;
        step();
        check("reenable_load", load, 1);
        check("reenable_count", respawnCount, 10);
        check("reenable_x", initialX, exp_x());
        step();
        check("reenable_load_end", load, 0);

        // reset asserted during the LOAD cycle
        enable = 1'b0;
        step();
        enable = 1'b1;
        step();
        check("pre_reset_load", load, 1);
        #2 resetN = 1'b0;
        enable = 1'b0;
        #1;
        check("reset_async_load", load, 0);
        check("reset_speed", speed, 64);
        check("reset_count", respawnCount, 0);
        check("reset_initialX", initialX, 0);
        check("reset_visible", visible, 0);
        repeat (3) @(posedge clk);
        #1 resetN = 1'b1;
        repeat (10) step();
        enable = 1'b1;
        step();
        check("post_reset_load", load, 1);
        check("lfsr_repeat", initialX, first_x);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
